divider_scheduler: RTL and testbench
====================================

Name: divider_scheduler

Overview:
- Runtime-reconfigurable clock-divider controller for the miner fabric.
- Owns the divide counter. Accepts new division values over a valid/ready handshake and applies them only at a period boundary, so the divided output never produces a runt phase.
- Outputs a divided clock level plus a one-cycle tick (clock enable) for downstream hashing/UART pacing logic.
- Supports start/stop through an enable input.

Parameters:
- WIDTH, 32, width of the division value and internal counter.
- DEFAULT_DIVISION, 1000, active division value after reset.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset; priority over all other inputs.
- enable  input  1  1 = run divider, 0 = stop and hold idle.
- cfg_valid  input  1  requester presents a new division value.
- cfg_ready  output  1  block can accept a value; combinational, equals (state != PENDING).
- cfg_division  input  WIDTH  requested division value D; any value 0..2^WIDTH-1 is legal.
- divided_clock  output  1  registered divided level; toggles once every D+1 running cycles.
- tick  output  1  registered one-cycle pulse, coincident with every divided_clock toggle.
- active_division  output  WIDTH  division value currently in force.

Behaviour:
- Reset (sampled high at a rising edge), values next cycle:
  - state = IDLE, counter = 0, divided_clock = 0, tick = 0
  - active_division = DEFAULT_DIVISION, shadow = DEFAULT_DIVISION, cfg_ready = 1
- Handshake: transfer occurs on a cycle where cfg_valid && cfg_ready. cfg_division is sampled in that cycle only.
- States:
  - IDLE:
    - counter held at 0, divided_clock 0, tick 0.
    - On transfer: active_division <= cfg_division.
    - If enable = 1: go to RUN. Counter starts at 0; increments begin the following cycle.
    - Transfer and enable in the same cycle: the new value applies and the block goes to RUN.
  - RUN:
    - Each cycle, if counter == active_division (wrap): counter <= 0, divided_clock <= ~divided_clock, tick <= 1.
    - Otherwise: counter <= counter + 1, tick <= 0.
    - On transfer: shadow <= cfg_division, go to PENDING. Counting continues unaffected.
  - PENDING:
    - Counting identical to RUN; cfg_ready = 0.
    - At wrap: the toggle and tick occur with the old period, then active_division <= shadow, counter <= 0, go to RUN.
    - The first full period after the wrap uses the new value.
- Disable (enable = 0 in RUN or PENDING), values next cycle:
  - counter = 0, divided_clock = 0, tick = 0, state = IDLE.
  - If coming from PENDING: active_division <= shadow.
  - Disable takes priority over a coincident wrap: no tick is emitted.
- Timing: with D = active_division, tick period = D+1 cycles and divided_clock period = 2(D+1) cycles.
  - First tick is D+1 cycles after the RUN-entry edge.
  - D = 0: divided_clock toggles every cycle and tick stays high continuously.
- Arithmetic: counter is WIDTH bits and compared by equality only. The counter never exceeds active_division, so no overflow is possible.
- Reset mid-operation: any pending shadow value is discarded; all outputs return to their reset values.

Test Plan:
1. Reset, then enable = 1 with no configuration -> active_division = 1000; first tick 1001 cycles after RUN entry, then every 1001 cycles; divided_clock is 0 before the first tick, 1 after it, and has period 2002.
2. In IDLE, transfer D = 3, then enable -> tick every 4 cycles; divided_clock waveform 0000 1111 0000…; active_division = 3 one cycle after the transfer.
3. Running with D = 3, transfer D = 1 when counter = 1 ->
   - cfg_ready drops the next cycle; a second cfg_valid is held off.
   - Wrap occurs 2 cycles later at the old period, after which active_division = 1.
   - Subsequent ticks every 2 cycles; cfg_ready returns to 1.
4. Transfer D = 0 in IDLE, then enable -> tick constantly 1, divided_clock alternates every cycle.
5. In PENDING (shadow = 7), deassert enable in the cycle the wrap would occur -> no tick, divided_clock = 0, active_division = 7, state IDLE, cfg_ready = 1.
6. Assert reset mid-run with D = 5 and counter = 3 -> next cycle divided_clock = 0, tick = 0, active_division = 1000, cfg_ready = 1; simultaneous cfg_valid is ignored.

Source files
------------

// File: rtl/divider_scheduler.sv
// Runtime-reconfigurable clock divider: divided level plus one-cycle tick, new divisions applied only at period boundaries.
// Outputs registered (first tick D+1 cycles after RUN entry); cfg_ready is low while a staged value waits for the wrap.
module divider_scheduler #(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned DEFAULT_DIVISION = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_division,
  output logic             divided_clock,
  output logic             tick,
  output logic [WIDTH-1:0] active_division
);

  typedef enum logic [1:0] {IDLE, RUN, PENDING} state_t;

  state_t           state;
  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] shadow;
  logic             xfer;
  logic             wrap;

  assign cfg_ready = (state != PENDING);
  assign xfer      = cfg_valid && cfg_ready;
  assign wrap      = (counter == active_division);

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      counter         <= '0;
      divided_clock   <= 1'b0;
      tick            <= 1'b0;
      active_division <= WIDTH'(DEFAULT_DIVISION);
      shadow          <= WIDTH'(DEFAULT_DIVISION);
    end else begin
      case (state)
        IDLE: begin
          counter       <= '0;
          divided_clock <= 1'b0;
          tick          <= 1'b0;
          if (xfer)
            active_division <= cfg_division;
          if (enable)
            state <= RUN;
        end
        RUN, PENDING: begin
          if (!enable) begin
            // Stopping is itself a period boundary, so any staged value takes effect now.
            counter       <= '0;
            divided_clock <= 1'b0;
            tick          <= 1'b0;
            state         <= IDLE;
            if (state == PENDING)
              active_division <= shadow;
            else if (xfer)
              active_division <= cfg_division;
          end else begin
            if (wrap) begin
              counter       <= '0;
              divided_clock <= ~divided_clock;
              tick          <= 1'b1;
            end else begin
              counter <= counter + WIDTH'(1);
              tick    <= 1'b0;
            end
            if (state == PENDING) begin
              if (wrap) begin
                active_division <= shadow;
                state           <= RUN;
              end
            end else if (xfer) begin
              shadow <= cfg_division;
              state  <= PENDING;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_scheduler.sv
// Directed bench for divider_scheduler: hand-computed tick/level patterns, reconfiguration and disable/reset corners.
module tb_divider_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_division;
  logic        divided_clock;
  logic        tick;
  logic [31:0] active_division;

  int n_total = 0;
  int n_bad   = 0;

  divider_scheduler #(.WIDTH(32), .DEFAULT_DIVISION(1000)) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_division    (cfg_division),
    .divided_clock   (divided_clock),
    .tick            (tick),
    .active_division (active_division)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < limit);
  endtask

  task automatic run_pat(input int cnt, output logic [15:0] tk, output logic [15:0] dc);
    tk = '0;
    dc = '0;
    for (int i = 0; i < cnt; i++) begin
      step();
      tk[i] = tick;
      dc[i] = divided_clock;
    end
  endtask

  task automatic xfer_idle(input logic [31:0] d);
    cfg_valid    = 1'b1;
    cfg_division = d;
    step();
    cfg_valid    = 1'b0;
  endtask

  initial begin
    int          n;
    logic [15:0] tk;
    logic [15:0] dc;

    reset        = 1'b1;
    enable       = 1'b0;
    cfg_valid    = 1'b0;
    cfg_division = '0;
    step();
    reset = 1'b0;
    chk("rst_dc", {31'd0, divided_clock}, 0);
    chk("rst_tick", {31'd0, tick}, 0);
    chk("rst_active", active_division, 1000);
    chk("rst_ready", {31'd0, cfg_ready}, 1);

    // Default division: tick 1001 cycles after RUN entry, level period 2002.
    enable = 1'b1;
    step();
    chk("def_dc_before", {31'd0, divided_clock}, 0);
    wait_tick(1100, n);
    chk("def_first_tick", n, 1001);
    chk("def_dc_high", {31'd0, divided_clock}, 1);
    wait_tick(1100, n);
    chk("def_second_tick", n, 1001);
    chk("def_dc_low", {31'd0, divided_clock}, 0);
    enable = 1'b0;
    step();
    chk("stop_dc", {31'd0, divided_clock}, 0);

    // D = 3 loaded in IDLE.
    xfer_idle(32'd3);
    chk("d3_active", active_division, 3);
    enable = 1'b1;
    step();
    run_pat(12, tk, dc);
    chk("d3_tick_pat", {16'd0, tk}, 32'h0888);
    chk("d3_dc_pat", {16'd0, dc}, 32'h0878);

    // Reconfigure to D = 1 mid-period while counter = 1.
    step();
    cfg_valid    = 1'b1;
    cfg_division = 32'd1;
    step();
    chk("pend_ready_low", {31'd0, cfg_ready}, 0);
    cfg_division = 32'd9;
    chk("pend_active_old", active_division, 3);
    step();
    chk("pend_no_tick", {31'd0, tick}, 0);
    step();
    chk("pend_wrap_tick", {31'd0, tick}, 1);
    chk("pend_new_active", active_division, 1);
    chk("pend_ready_back", {31'd0, cfg_ready}, 1);
    cfg_valid = 1'b0;
    run_pat(4, tk, dc);
    chk("d1_tick_pat", {16'd0, tk}, 32'h000a);
    chk("held_off_value", active_division, 1);

    // D = 0: tick stuck high, level toggles each cycle.
    enable = 1'b0;
    step();
    xfer_idle(32'd0);
    enable = 1'b1;
    step();
    run_pat(6, tk, dc);
    chk("d0_tick_pat", {16'd0, tk}, 32'h003f);
    chk("d0_dc_pat", {16'd0, dc}, 32'h0015);

    // Disable in PENDING on the wrap cycle.
    enable = 1'b0;
    step();
    xfer_idle(32'd3);
    enable = 1'b1;
    step();
    step();
    cfg_valid    = 1'b1;
    cfg_division = 32'd7;
    step();
    cfg_valid = 1'b0;
    chk("p7_ready_low", {31'd0, cfg_ready}, 0);
    step();
    enable = 1'b0;
    step();
    chk("dis_tick", {31'd0, tick}, 0);
    chk("dis_dc", {31'd0, divided_clock}, 0);
    chk("dis_active", active_division, 7);
    chk("dis_ready", {31'd0, cfg_ready}, 1);

    // Reset mid-run with D = 5, counter = 3, after one wrap.
    cfg_valid    = 1'b1;
    cfg_division = 32'd5;
    enable       = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("d5_active", active_division, 5);
    for (int i = 0; i < 9; i++) step();
    chk("d5_dc_high", {31'd0, divided_clock}, 1);
    reset        = 1'b1;
    cfg_valid    = 1'b1;
    cfg_division = 32'd2;
    step();
    reset     = 1'b0;
    cfg_valid = 1'b0;
    enable    = 1'b0;
    chk("mrst_dc", {31'd0, divided_clock}, 0);
    chk("mrst_tick", {31'd0, tick}, 0);
    chk("mrst_active", active_division, 1000);
    chk("mrst_ready", {31'd0, cfg_ready}, 1);
    step();
    chk("mrst_active_hold", active_division, 1000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
